// File: rtl/snake_body_writer.sv
// Write side of the snake-body position store: latches direction, computes the
// next head, shifts the body list toward the tail and writes the new head.
module snake_body_writer #(
  parameter int                         GRID_BITS = 2,
  parameter logic [2*GRID_BITS-1:0]     INIT_HEAD = 4'b0101
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               buttons,
  input  logic                     step,
  input  logic                     grow,
  input  logic [2*GRID_BITS-1:0]   read_addr,
  output logic [2*GRID_BITS-1:0]   read_data,
  output logic [2*GRID_BITS:0]     length,
  output logic                     busy,
  output logic                     done,
  output logic                     wall_hit,
  output logic                     self_hit
);

  localparam int P = 2 * GRID_BITS;
  localparam int D = 1 << P;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HEAD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [GRID_BITS-1:0] C_ONE   = GRID_BITS'(1);
  localparam logic [GRID_BITS-1:0] C_MAX   = '1;
  localparam logic [P-1:0]         IDX_ONE = P'(1);
  localparam logic [P:0]           LEN_ONE = (P+1)'(1);
  localparam logic [P:0]           LEN_MAX = (P+1)'(D);
  localparam logic [3:0]           DIR_RIGHT = 4'b1000;

  logic [1:0]           r_state;
  logic [3:0]           r_dir;
  logic [3:0]           r_last_dir;
  logic [P-1:0]         r_mem [D];
  logic [P-1:0]         r_nh;
  logic [P-1:0]         r_idx;
  logic                 r_g;
  logic [P:0]           r_len;
  logic                 r_wall;
  logic                 r_self;

  logic [GRID_BITS-1:0] w_row, w_col, w_nrow, w_ncol;
  logic [P-1:0]         w_nh;
  logic [P-1:0]         w_n;
  logic [P-1:0]         w_src;
  logic [3:0]           w_opp;
  logic                 w_wall;
  logic                 w_g;
  logic                 w_btn_ok;

  assign w_row = r_mem[0][P-1:GRID_BITS];
  assign w_col = r_mem[0][GRID_BITS-1:0];

  always_comb begin
    w_nrow = w_row;
    w_ncol = w_col;
    if (r_dir[0]) w_nrow = w_row - C_ONE;
    if (r_dir[1]) w_nrow = w_row + C_ONE;
    if (r_dir[2]) w_ncol = w_col - C_ONE;
    if (r_dir[3]) w_ncol = w_col + C_ONE;
  end

  assign w_nh   = {w_nrow, w_ncol};
  assign w_wall = (r_dir[0] && (w_row == '0))  || (r_dir[1] && (w_row == C_MAX)) ||
                  (r_dir[2] && (w_col == '0))  || (r_dir[3] && (w_col == C_MAX));
  assign w_g    = grow && (r_len < LEN_MAX);
  // Number of shift cycles: old length minus one, plus one slot when growing.
  assign w_n    = P'(r_len - LEN_ONE + {{P{1'b0}}, w_g});
  assign w_src  = r_mem[r_idx - IDX_ONE];

  // Reversal is only forbidden once there is a neck to run into.
  assign w_opp    = {r_last_dir[2], r_last_dir[3], r_last_dir[0], r_last_dir[1]};
  assign w_btn_ok = $onehot(buttons) && !((r_len > LEN_ONE) && (buttons == w_opp));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_dir      <= DIR_RIGHT;
      r_last_dir <= DIR_RIGHT;
      r_nh       <= '0;
      r_idx      <= '0;
      r_g        <= 1'b0;
      r_len      <= LEN_ONE;
      r_wall     <= 1'b0;
      r_self     <= 1'b0;
      for (int i = 0; i < D; i++) r_mem[i] <= '0;
      r_mem[0]   <= INIT_HEAD;
    end else begin
      if (w_btn_ok) r_dir <= buttons;
      case (r_state)
        S_IDLE: begin
          if (step) begin
            if (w_wall) begin
              r_wall  <= 1'b1;
              r_self  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_nh       <= w_nh;
              r_g        <= w_g;
              r_wall     <= 1'b0;
              r_self     <= 1'b0;
              r_last_dir <= r_dir;
              r_idx      <= w_n;
              r_state    <= (w_n != '0) ? S_SHIFT : S_HEAD;
            end
          end
        end
        S_SHIFT: begin
          r_mem[r_idx] <= w_src;
          if (w_src == r_nh) r_self <= 1'b1;
          r_idx <= r_idx - IDX_ONE;
          if (r_idx == IDX_ONE) r_state <= S_HEAD;
        end
        S_HEAD: begin
          r_mem[0] <= r_nh;
          r_len    <= r_len + {{P{1'b0}}, r_g};
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_data = r_mem[read_addr];
  assign length    = r_len;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign wall_hit  = r_wall;
  assign self_hit  = r_self;

endmodule

// File: tb/tb_snake_body_writer.sv
// Directed bench for snake_body_writer: a table of moves plus hand sequences.
module tb_snake_body_writer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] buttons = 4'b0000;
  logic       step = 1'b0;
  logic       grow = 1'b0;
  logic [3:0] read_addr = 4'd0;
  logic [3:0] read_data;
  logic [4:0] length;
  logic       busy, done, wall_hit, self_hit;

  int n_total = 0;
  int n_pass  = 0;

  snake_body_writer dut (
    .clock(clock), .reset(reset), .buttons(buttons), .step(step), .grow(grow),
    .read_addr(read_addr), .read_data(read_data), .length(length),
    .busy(busy), .done(done), .wall_hit(wall_hit), .self_hit(self_hit)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] btn;
    logic       g;
    int         lat;
    logic [3:0] head;
    int         len;
    logic       wall;
    logic       slf;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clock);
    buttons = b;
    @(negedge clock);
    buttons = 4'b0000;
  endtask

  task automatic rd(input int a, output int v);
    read_addr = 4'(a);
    #1;
    v = int'(read_data);
  endtask

  // Issues one step and returns the number of clock edges until done is seen.
  task automatic do_step(input logic g, output int lat);
    lat = -1;
    @(negedge clock);
    step = 1'b1;
    grow = g;
    @(posedge clock);
    #1;
    step = 1'b0;
    grow = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      if (done) begin
        lat = e;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (lat > 0) begin
      @(posedge clock);
      #1;
      chk("done_one_cycle", int'(done), 0);
      chk("busy_after_done", int'(busy), 0);
    end
  endtask

  // Three growing moves from reset: right, down, left.
  task automatic build_body();
    int lat;
    do_reset();
    do_step(1'b1, lat);
    chk("build_lat1", lat, 3);
    press(4'b0010);
    do_step(1'b1, lat);
    chk("build_lat2", lat, 4);
    press(4'b0100);
    do_step(1'b1, lat);
    chk("build_lat3", lat, 5);
  endtask

  initial begin
    int lat, v;

    vecs[0] = '{4'b0000, 1'b0, 2, 4'b0110, 1, 1'b0, 1'b0};
    vecs[1] = '{4'b0000, 1'b0, 2, 4'b0111, 1, 1'b0, 1'b0};
    vecs[2] = '{4'b0000, 1'b0, 1, 4'b0111, 1, 1'b1, 1'b0};
    vecs[3] = '{4'b0010, 1'b1, 3, 4'b1011, 2, 1'b0, 1'b0};
    vecs[4] = '{4'b0001, 1'b0, 3, 4'b1111, 2, 1'b0, 1'b0};
    vecs[5] = '{4'b0000, 1'b0, 1, 4'b1111, 2, 1'b1, 1'b0};
    vecs[6] = '{4'b0100, 1'b1, 4, 4'b1110, 3, 1'b0, 1'b0};

    // Reset state
    do_reset();
    rd(0, v);
    chk("rst_head", v, 5);
    rd(1, v);
    chk("rst_mem1", v, 0);
    chk("rst_len", int'(length), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wall", int'(wall_hit), 0);
    chk("rst_self", int'(self_hit), 0);

    // Table-driven move sequence from reset
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].btn != 4'b0000) press(vecs[i].btn);
      do_step(vecs[i].g, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      rd(0, v);
      chk($sformatf("v%0d_head", i), v, int'(vecs[i].head));
      chk($sformatf("v%0d_len", i), int'(length), vecs[i].len);
      chk($sformatf("v%0d_wall", i), int'(wall_hit), int'(vecs[i].wall));
      chk($sformatf("v%0d_self", i), int'(self_hit), int'(vecs[i].slf));
    end
    rd(1, v);
    chk("v6_mem1", v, 4'b1111);
    rd(2, v);
    chk("v6_mem2", v, 4'b1011);

    // Grow from reset keeps old head at index 1
    do_reset();
    do_step(1'b1, lat);
    chk("grow_lat", lat, 3);
    rd(0, v);
    chk("grow_head", v, 4'b0110);
    rd(1, v);
    chk("grow_mem1", v, 4'b0101);
    chk("grow_len", int'(length), 2);

    // Reversal ignored at length 2, perpendicular turn accepted
    press(4'b0100);
    do_step(1'b0, lat);
    rd(0, v);
    chk("rev_head", v, 4'b0111);
    press(4'b0010);
    do_step(1'b0, lat);
    chk("turn_lat", lat, 3);
    rd(0, v);
    chk("turn_head", v, 4'b1011);

    // Head onto the vacating tail cell: no hit
    build_body();
    rd(0, v); chk("body0", v, 4'b1001);
    rd(1, v); chk("body1", v, 4'b1010);
    rd(2, v); chk("body2", v, 4'b0110);
    rd(3, v); chk("body3", v, 4'b0101);
    press(4'b0001);
    do_step(1'b0, lat);
    chk("tail_lat", lat, 5);
    chk("tail_self", int'(self_hit), 0);
    rd(0, v);
    chk("tail_head", v, 4'b0101);
    chk("tail_len", int'(length), 4);

    // Same move with grow: tail is retained, so it is a hit
    build_body();
    press(4'b0001);
    do_step(1'b1, lat);
    chk("hit_lat", lat, 6);
    chk("hit_self", int'(self_hit), 1);
    chk("hit_len", int'(length), 5);
    rd(0, v);
    chk("hit_head", v, 4'b0101);
    rd(4, v);
    chk("hit_tail", v, 4'b0101);

    // Reset in the middle of a shift sequence
    build_body();
    press(4'b0001);
    @(negedge clock);
    step = 1'b1;
    grow = 1'b1;
    @(posedge clock);
    #1;
    step = 1'b0;
    grow = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_busy_before", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_len", int'(length), 1);
    rd(0, v);
    chk("mid_head", v, 5);
    rd(3, v);
    chk("mid_mem3", v, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("mid_no_done", int'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
